// File: rtl/sbox_share_ctrl.sv
// Shares NUM_SBOX AES SBox lookups between a 128-bit state SubBytes and a 32-bit key SubWord requester.
// Define SBOX_SHARE_RR_EN for round-robin arbitration instead of fixed key priority.
module sbox_share_ctrl #(
  parameter int unsigned NUM_SBOX = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [127:0] st_in,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [31:0]  key_in,
  output logic         st_out_valid,
  input  logic         st_out_ready,
  output logic [127:0] st_out,
  output logic         key_out_valid,
  input  logic         key_out_ready,
  output logic [31:0]  key_out,
  output logic         busy
);

  localparam int unsigned ST_CHUNKS  = 16 / NUM_SBOX;
  localparam int unsigned KEY_CHUNKS = 4 / NUM_SBOX;
  localparam int unsigned CNT_W      = 4;

  if (!(NUM_SBOX == 1 || NUM_SBOX == 2 || NUM_SBOX == 4)) begin : g_bad_num_sbox
    $error("sbox_share_ctrl: NUM_SBOX must be 1, 2 or 4");
  end

  localparam logic [0:255][7:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic [2:0] {IDLE, RUN_ST, RUN_KEY, HOLD_ST, HOLD_KEY} state_t;

  state_t                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [15:0][7:0]           work_q;
  logic [15:0][7:0]           work_d;
  logic [NUM_SBOX-1:0][7:0]   sb_in;
  logic [NUM_SBOX-1:0][7:0]   sb_out;
  logic [3:0]                 base_c;
  logic                       run_c;
  logic                       last_c;

  assign run_c  = (state_q == RUN_ST) || (state_q == RUN_KEY);
  assign base_c = 4'(cnt_q * CNT_W'(NUM_SBOX));
  assign last_c = ((state_q == RUN_ST)  && (cnt_q == CNT_W'(ST_CHUNKS - 1))) ||
                  ((state_q == RUN_KEY) && (cnt_q == CNT_W'(KEY_CHUNKS - 1)));

  // Current chunk feeds the SBoxes; inputs idle at zero outside RUN.
  always_comb begin
    sb_in = '0;
    if (run_c) begin
      for (int i = 0; i < NUM_SBOX; i++) begin
        sb_in[i] = work_q[base_c + 4'(i)];
      end
    end
  end

  for (genvar g = 0; g < NUM_SBOX; g++) begin : g_sbox
    assign sb_out[g] = SBOX_TBL[sb_in[g]];
  end

  // Substituted chunk written back in place.
  always_comb begin
    work_d = work_q;
    if (run_c) begin
      for (int i = 0; i < NUM_SBOX; i++) begin
        work_d[base_c + 4'(i)] = sb_out[i];
      end
    end
  end

`ifdef SBOX_SHARE_RR_EN
  localparam logic GRANT_ST  = 1'b0;
  localparam logic GRANT_KEY = 1'b1;
  logic last_grant_q;

  // On a collision the requester not served last wins.
  always_comb begin
    st_ready  = 1'b0;
    key_ready = 1'b0;
    if (state_q == IDLE) begin
      key_ready = !(st_valid && (last_grant_q == GRANT_KEY));
      st_ready  = !(key_valid && (last_grant_q == GRANT_ST));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= GRANT_ST;
    end else if (state_q == IDLE) begin
      if (key_valid && key_ready) begin
        last_grant_q <= GRANT_KEY;
      end else if (st_valid && st_ready) begin
        last_grant_q <= GRANT_ST;
      end
    end
  end
`else
  always_comb begin
    st_ready  = 1'b0;
    key_ready = 1'b0;
    if (state_q == IDLE) begin
      key_ready = 1'b1;
      st_ready  = !key_valid;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      work_q        <= '0;
      st_out        <= '0;
      key_out       <= '0;
      st_out_valid  <= 1'b0;
      key_out_valid <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (key_valid && key_ready) begin
            work_q  <= 128'(key_in);
            cnt_q   <= '0;
            state_q <= RUN_KEY;
            busy    <= 1'b1;
          end else if (st_valid && st_ready) begin
            work_q  <= st_in;
            cnt_q   <= '0;
            state_q <= RUN_ST;
            busy    <= 1'b1;
          end
        end
        RUN_ST: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_c) begin
            st_out       <= work_d;
            st_out_valid <= 1'b1;
            state_q      <= HOLD_ST;
          end
        end
        RUN_KEY: begin
          work_q <= work_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (last_c) begin
            key_out       <= work_d[3:0];
            key_out_valid <= 1'b1;
            state_q       <= HOLD_KEY;
          end
        end
        HOLD_ST: begin
          if (st_out_ready) begin
            st_out_valid <= 1'b0;
            state_q      <= IDLE;
            busy         <= 1'b0;
          end
        end
        HOLD_KEY: begin
          if (key_out_ready) begin
            key_out_valid <= 1'b0;
            state_q       <= IDLE;
            busy          <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
